cascade_stage_scheduler: RTL and testbench

Sequences one Haar-cascade evaluation of a single integral-image window on the FPGA clock. On a start pulse it walks the stage database in ROM stage by stage and streams every classifier parameter word, tagged with stage/classifier/parameter indices, to the stage evaluator. After each stage it waits for the evaluator's pass/fail verdict, exits early on the first failing stage, and reports the window as a face candidate only if every stage passes. It sits between the window controller, the database ROM and the classifier datapath.

---
 rtl/cascade_stage_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_cascade_stage_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_stage_scheduler.sv
// cascade_stage_scheduler
//   Sequences one Haar-cascade evaluation of an integral-image window. It walks
//   the stage database in ROM one stage at a time and streams each classifier
//   parameter word to the stage evaluator, tagged with its stage, classifier and
//   parameter indices. After each stage it waits for the evaluator's verdict. It
//   exits early on the first failing stage. The window is reported as a face
//   candidate only if every stage passes.
//
//   Database layout, contiguous from address 0: for each stage, one count word N,
//   followed by N*NUM_PARAM_PER_CLASSIFIER parameter words.
//
// Ports
//   clk_fpga, reset_fpga          clock, synchronous active-high reset
//   i_start, i_abort              begin cascade / abandon current window
//   o_rom_en, o_rom_addr          ROM read request (data returns next cycle)
//   i_rom_data                    ROM read data
//   o_param_valid, o_param_data   parameter word stream to the evaluator
//   o_index_stage/classifier/param  tags for the current word
//   o_end_single_classifier       last word of a classifier
//   o_end_stage                   last word of a stage
//   i_stage_result_valid, i_stage_pass  evaluator verdict
//   o_busy, o_done, o_candidate   status and result
module cascade_stage_scheduler #(
    parameter int DATA_WIDTH_12            = 12,
    parameter int ADDR_WIDTH               = 16,
    parameter int NUM_STAGE                = 24,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_start,
    input  logic                     i_abort,
    output logic                     o_rom_en,
    output logic [ADDR_WIDTH-1:0]    o_rom_addr,
    input  logic [DATA_WIDTH_12-1:0] i_rom_data,
    output logic                     o_param_valid,
    output logic [DATA_WIDTH_12-1:0] o_param_data,
    output logic [DATA_WIDTH_12-1:0] o_index_stage,
    output logic [DATA_WIDTH_12-1:0] o_index_classifier,
    output logic [DATA_WIDTH_12-1:0] o_index_param,
    output logic                     o_end_single_classifier,
    output logic                     o_end_stage,
    input  logic                     i_stage_result_valid,
    input  logic                     i_stage_pass,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_candidate
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] FETCH_COUNT = 3'd1;
    localparam logic [2:0] WAIT_COUNT  = 3'd2;
    localparam logic [2:0] STREAM      = 3'd3;
    localparam logic [2:0] DRAIN       = 3'd4;
    localparam logic [2:0] WAIT_RESULT = 3'd5;
    localparam logic [2:0] DONE        = 3'd6;

    localparam logic [DATA_WIDTH_12-1:0] LAST_PARAM = DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER - 1);
    localparam logic [DATA_WIDTH_12-1:0] LAST_STAGE = DATA_WIDTH_12'(NUM_STAGE - 1);
    localparam logic [DATA_WIDTH_12-1:0] ONE        = DATA_WIDTH_12'(1);

    logic [2:0]               state;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH_12-1:0] stage_cnt;
    logic [DATA_WIDTH_12-1:0] cls_cnt;
    logic [DATA_WIDTH_12-1:0] param_cnt;
    logic [DATA_WIDTH_12-1:0] num_cls;
    logic                     param_valid_q;
    logic                     last_stage;
    logic                     last_param;
    logic                     last_word;

    assign last_stage = (stage_cnt == LAST_STAGE);
    assign last_param = (param_cnt == LAST_PARAM);
    assign last_word  = last_param && (cls_cnt == num_cls - ONE);

    // addr always points at the next word to read. It runs straight through the
    // database, so after the last parameter of a stage it already holds the next
    // stage's count address.
    assign o_rom_en   = (state == FETCH_COUNT) || (state == STREAM);
    assign o_rom_addr = addr;
    assign o_busy     = (state != IDLE);
    assign o_done     = (state == DONE);

    // The tags are registered alongside the read, and the word itself arrives from
    // the ROM in the following cycle. Gating the ROM output with the registered
    // valid bit keeps the word aligned with its tags and forces it to zero otherwise.
    assign o_param_valid = param_valid_q;
    assign o_param_data  = param_valid_q ? i_rom_data : '0;

    always_ff @(posedge clk_fpga) begin
        if (reset_fpga) begin
            state                   <= IDLE;
            addr                    <= '0;
            stage_cnt               <= '0;
            cls_cnt                 <= '0;
            param_cnt               <= '0;
            num_cls                 <= '0;
            param_valid_q           <= 1'b0;
            o_index_stage           <= '0;
            o_index_classifier      <= '0;
            o_index_param           <= '0;
            o_end_single_classifier <= 1'b0;
            o_end_stage             <= 1'b0;
            o_candidate             <= 1'b0;
        end else begin
            param_valid_q           <= 1'b0;
            o_end_single_classifier <= 1'b0;
            o_end_stage             <= 1'b0;
            if (i_abort && (state != IDLE)) begin
                state       <= IDLE;
                o_candidate <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            addr        <= '0;
                            stage_cnt   <= '0;
                            o_candidate <= 1'b0;
                            state       <= FETCH_COUNT;
                        end
                    end
                    FETCH_COUNT: begin
                        addr  <= addr + 1'b1;
                        state <= WAIT_COUNT;
                    end
                    WAIT_COUNT: begin
                        num_cls   <= i_rom_data;
                        cls_cnt   <= '0;
                        param_cnt <= '0;
                        if (i_rom_data == '0) begin
                            // An empty stage passes without a verdict.
                            if (last_stage) begin
                                o_candidate <= 1'b1;
                                state       <= DONE;
                            end else begin
                                stage_cnt <= stage_cnt + ONE;
                                state     <= FETCH_COUNT;
                            end
                        end else begin
                            state <= STREAM;
                        end
                    end
                    STREAM: begin
                        addr                    <= addr + 1'b1;
                        param_valid_q           <= 1'b1;
                        o_index_stage           <= stage_cnt;
                        o_index_classifier      <= cls_cnt;
                        o_index_param           <= param_cnt;
                        o_end_single_classifier <= last_param;
                        o_end_stage             <= last_word;
                        if (last_param) begin
                            param_cnt <= '0;
                            cls_cnt   <= cls_cnt + ONE;
                        end else begin
                            param_cnt <= param_cnt + ONE;
                        end
                        if (last_word) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        state <= WAIT_RESULT;
                    end
                    WAIT_RESULT: begin
                        if (i_stage_result_valid) begin
                            if (!i_stage_pass) begin
                                o_candidate <= 1'b0;
                                state       <= DONE;
                            end else if (last_stage) begin
                                o_candidate <= 1'b1;
                                state       <= DONE;
                            end else begin
                                stage_cnt <= stage_cnt + ONE;
                                state     <= FETCH_COUNT;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cascade_stage_scheduler.sv
// tb_cascade_stage_scheduler
//   Scoreboard bench for cascade_stage_scheduler with a 3-stage database held in
//   a behavioural ROM. The expected parameter words, with their tags, are queued
//   before each window starts. A negedge monitor pops and compares every word
//   the DUT streams and logs every ROM read address. Each scenario task checks
//   timing, result and address sequence inline.
module tb_cascade_stage_scheduler;

    localparam int DW = 12;
    localparam int AW = 16;
    localparam int NP = 18;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data = '0;
    logic          pvalid;
    logic [DW-1:0] pdata;
    logic [DW-1:0] idx_s;
    logic [DW-1:0] idx_c;
    logic [DW-1:0] idx_p;
    logic          end_c;
    logic          end_s;
    logic          rs_valid = 1'b0;
    logic          rs_pass = 1'b0;
    logic          busy;
    logic          done;
    logic          cand;
    logic [70:0]   all_out;

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] stage;
        logic [DW-1:0] cls;
        logic [DW-1:0] param;
        logic          endc;
        logic          ends;
    } exp_t;

    exp_t        exp_q[$];
    int          addr_log[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ncls[NS];
    logic [DW-1:0] rom[0:255];

    cascade_stage_scheduler #(
        .DATA_WIDTH_12(DW),
        .ADDR_WIDTH(AW),
        .NUM_STAGE(NS),
        .NUM_PARAM_PER_CLASSIFIER(NP)
    ) dut (
        .clk_fpga(clk),
        .reset_fpga(reset),
        .i_start(start),
        .i_abort(abort),
        .o_rom_en(rom_en),
        .o_rom_addr(rom_addr),
        .i_rom_data(rom_data),
        .o_param_valid(pvalid),
        .o_param_data(pdata),
        .o_index_stage(idx_s),
        .o_index_classifier(idx_c),
        .o_index_param(idx_p),
        .o_end_single_classifier(end_c),
        .o_end_stage(end_s),
        .i_stage_result_valid(rs_valid),
        .i_stage_pass(rs_pass),
        .o_busy(busy),
        .o_done(done),
        .o_candidate(cand)
    );

    assign all_out = {rom_en, rom_addr, pvalid, pdata, idx_s, idx_c, idx_p, end_c, end_s, busy, done, cand};

    always #5 clk = ~clk;

    // Behavioural ROM with one-cycle read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr[7:0]];
    end

    // Scoreboard monitor: pop and compare each streamed word, and log ROM reads.
    always @(negedge clk) begin
        exp_t e;
        if (rom_en === 1'b1) addr_log.push_back(int'(rom_addr));
        if (pvalid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got data=%h stage=%0d cls=%0d param=%0d, required no word",
                         pdata, idx_s, idx_c, idx_p);
            end else begin
                e = exp_q.pop_front();
                if ({pdata, idx_s, idx_c, idx_p, end_c, end_s} !==
                    {e.data, e.stage, e.cls, e.param, e.endc, e.ends}) begin
                    miscompares++;
                    $display("FAIL param_word: got data=%h s=%0d c=%0d p=%0d endc=%b ends=%b, required data=%h s=%0d c=%0d p=%0d endc=%b ends=%b",
                             pdata, idx_s, idx_c, idx_p, end_c, end_s,
                             e.data, e.stage, e.cls, e.param, e.endc, e.ends);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_db(input int n0, input int n1, input int n2);
        int a;
        ncls[0] = n0;
        ncls[1] = n1;
        ncls[2] = n2;
        for (int i = 0; i < 256; i++) rom[i] = DW'((i * 37 + 5) ^ 'hA5A);
        a = 0;
        for (int s = 0; s < NS; s++) begin
            rom[a] = DW'(ncls[s]);
            a += 1 + ncls[s] * NP;
        end
    endtask

    task automatic push_expected(input int max_words);
        exp_t e;
        int   a;
        int   k;
        a = 0;
        k = 0;
        for (int s = 0; s < NS; s++) begin
            a++;
            for (int c = 0; c < ncls[s]; c++) begin
                for (int p = 0; p < NP; p++) begin
                    if (k < max_words) begin
                        e.data  = rom[a];
                        e.stage = DW'(s);
                        e.cls   = DW'(c);
                        e.param = DW'(p);
                        e.endc  = (p == NP - 1);
                        e.ends  = (p == NP - 1) && (c == ncls[s] - 1);
                        exp_q.push_back(e);
                    end
                    a++;
                    k++;
                end
            end
        end
    endtask

    // Runs one window; answers each stage after its last word, failing stage
    // fail_stage (-1 = all pass). With noise, also pulses i_start and a spurious
    // fail verdict during STREAM, and delays each verdict with i_start pulses.
    task automatic run_cascade(input int fail_stage, input bit noise,
                               output int done_t, output logic cand_o,
                               output int busy_t, output int valid_t, output int rd19_t);
        bit pend;
        int vwait;
        int stage_idx;
        done_t = -1; busy_t = -1; valid_t = -1; rd19_t = -1; cand_o = 1'bx;
        pend = 0; vwait = 0; stage_idx = 0;
        addr_log.delete();
        tick();
        start = 1'b1;
        for (int t = 1; t <= 400 && done_t < 0; t++) begin
            tick();
            start = 1'b0; rs_valid = 1'b0; rs_pass = 1'b0;
            if (busy && busy_t < 0) busy_t = t;
            if (pvalid && valid_t < 0) valid_t = t;
            if (rom_en && rom_addr == 16'd19 && rd19_t < 0) rd19_t = t;
            if (done) begin done_t = t; cand_o = cand; end
            if (pend) begin
                if (vwait > 0) begin
                    vwait--;
                    if (noise) start = 1'b1;
                end else begin
                    rs_valid = 1'b1;
                    rs_pass  = (stage_idx != fail_stage);
                    stage_idx++;
                    pend = 0;
                end
            end
            if (end_s) begin pend = 1; vwait = noise ? 3 : 0; end
            if (noise && pvalid && idx_p == 12'd3) start = 1'b1;
            if (noise && pvalid && idx_p == 12'd7) begin rs_valid = 1'b1; rs_pass = 1'b0; end
        end
        start = 1'b0; rs_valid = 1'b0; rs_pass = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL idle_outputs: got %h, required 0", all_out);
        end
    endtask

    task automatic test_pass_timing();
        int done_t, busy_t, valid_t, rd19_t;
        logic c;
        bit bad;
        load_db(1, 2, 0);
        push_expected(1000);
        run_cascade(-1, 0, done_t, c, busy_t, valid_t, rd19_t);
        vectors++;
        if (busy_t !== 1) begin miscompares++; $display("FAIL pass_busy_cycle: got %0d, required 1", busy_t); end
        vectors++;
        if (valid_t !== 4) begin miscompares++; $display("FAIL pass_first_valid: got %0d, required 4", valid_t); end
        vectors++;
        if (rd19_t !== 23) begin miscompares++; $display("FAIL pass_stage1_count_read: got %0d, required 23", rd19_t); end
        vectors++;
        if (done_t !== 65) begin miscompares++; $display("FAIL pass_done_cycle: got %0d, required 65", done_t); end
        vectors++;
        if (c !== 1'b1) begin miscompares++; $display("FAIL pass_candidate: got %b, required 1", c); end
        bad = (addr_log.size() != 57);
        foreach (addr_log[i]) if (addr_log[i] != i) bad = 1;
        vectors++;
        if (bad) begin miscompares++; $display("FAIL pass_addr_seq: got %0d reads, required 0..56", addr_log.size()); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL pass_words_left: got %0d, required 0", exp_q.size()); end
        tick();
        vectors++;
        if ({busy, done, cand} !== 3'b001) begin miscompares++; $display("FAIL pass_after_done: got busy/done/cand %b, required 001", {busy, done, cand}); end
    endtask

    task automatic test_fail_early();
        int done_t, busy_t, valid_t, rd19_t;
        logic c;
        bit bad;
        load_db(2, 1, 1);
        push_expected(36);
        run_cascade(0, 0, done_t, c, busy_t, valid_t, rd19_t);
        vectors++;
        if (done_t !== 41) begin miscompares++; $display("FAIL fail_done_cycle: got %0d, required 41", done_t); end
        vectors++;
        if (c !== 1'b0) begin miscompares++; $display("FAIL fail_candidate: got %b, required 0", c); end
        bad = (addr_log.size() != 37);
        foreach (addr_log[i]) if (addr_log[i] != i) bad = 1;
        vectors++;
        if (bad) begin miscompares++; $display("FAIL fail_addr_seq: got %0d reads, required 0..36", addr_log.size()); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL fail_words_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_zero_stage();
        int done_t, busy_t, valid_t, rd19_t;
        logic c;
        bit bad;
        load_db(1, 0, 1);
        push_expected(1000);
        run_cascade(-1, 0, done_t, c, busy_t, valid_t, rd19_t);
        vectors++;
        if (rd19_t !== 23) begin miscompares++; $display("FAIL zero_count_read: got %0d, required 23", rd19_t); end
        vectors++;
        if (done_t !== 47) begin miscompares++; $display("FAIL zero_done_cycle: got %0d, required 47", done_t); end
        vectors++;
        if (c !== 1'b1) begin miscompares++; $display("FAIL zero_candidate: got %b, required 1", c); end
        bad = (addr_log.size() != 39);
        foreach (addr_log[i]) if (addr_log[i] != i) bad = 1;
        vectors++;
        if (bad) begin miscompares++; $display("FAIL zero_addr_seq: got %0d reads, required 0..38", addr_log.size()); end
    endtask

    task automatic test_abort();
        int done_t, busy_t, valid_t, rd19_t;
        int words;
        int guard;
        int dones;
        logic c;
        bit bad;
        load_db(1, 1, 1);
        push_expected(5);
        addr_log.delete();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        words = 0;
        guard = 0;
        while (words < 5 && guard < 50) begin
            tick();
            guard++;
            if (pvalid) words++;
        end
        vectors++;
        if (words != 5) begin miscompares++; $display("FAIL abort_timeout: got %0d words, required 5", words); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({busy, pvalid, done, cand} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy/valid/done/cand %b, required 0000", {busy, pvalid, done, cand});
        end
        dones = 0;
        repeat (4) begin tick(); if (done || busy) dones++; end
        vectors++;
        if (dones != 0) begin miscompares++; $display("FAIL abort_stays_idle: got %0d active cycles, required 0", dones); end
        bad = (addr_log.size() != 7);
        foreach (addr_log[i]) if (addr_log[i] != i) bad = 1;
        vectors++;
        if (bad) begin miscompares++; $display("FAIL abort_addr_seq: got %0d reads, required 0..6", addr_log.size()); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL abort_words_left: got %0d, required 0", exp_q.size()); end
        push_expected(1000);
        run_cascade(-1, 0, done_t, c, busy_t, valid_t, rd19_t);
        bad = (addr_log.size() != 57);
        foreach (addr_log[i]) if (addr_log[i] != i) bad = 1;
        vectors++;
        if (bad) begin miscompares++; $display("FAIL restart_addr_seq: got %0d reads, required 0..56", addr_log.size()); end
        vectors++;
        if (c !== 1'b1) begin miscompares++; $display("FAIL restart_candidate: got %b, required 1", c); end
    endtask

    task automatic test_ignored_inputs();
        int done_t, busy_t, valid_t, rd19_t;
        logic c;
        bit bad;
        load_db(2, 1, 1);
        push_expected(1000);
        run_cascade(-1, 1, done_t, c, busy_t, valid_t, rd19_t);
        vectors++;
        if (done_t < 0) begin miscompares++; $display("FAIL noise_timeout: got no o_done, required o_done"); end
        vectors++;
        if (c !== 1'b1) begin miscompares++; $display("FAIL noise_candidate: got %b, required 1", c); end
        bad = (addr_log.size() != 75);
        foreach (addr_log[i]) if (addr_log[i] != i) bad = 1;
        vectors++;
        if (bad) begin miscompares++; $display("FAIL noise_addr_seq: got %0d reads, required 0..74", addr_log.size()); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL noise_words_left: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_in_wait();
        int guard;
        load_db(1, 0, 0);
        push_expected(1000);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!end_s && guard < 50) begin tick(); guard++; end
        vectors++;
        if (!end_s) begin miscompares++; $display("FAIL rstwait_timeout: got no o_end_stage, required o_end_stage"); end
        repeat (3) tick();
        vectors++;
        if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL rstwait_waiting: got busy/done %b, required 10", {busy, done}); end
        reset = 1'b1;
        tick();
        vectors++;
        if (all_out !== '0) begin miscompares++; $display("FAIL rstwait_outputs: got %h, required 0", all_out); end
        reset = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rstwait_idle: got busy %b, required 0", busy); end
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rstwait_words_left: got %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_pass_timing();
        test_fail_early();
        test_zero_stage();
        test_abort();
        test_ignored_inputs();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
